// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the 2 MB SRAM arbiter.
//   - state_e  : access sequencer states
//   - req_id_t : requester identifiers (video, CPU, DMA)
//   - DEF_*    : default parameter values
package sram_arb_pkg;

    localparam int unsigned DEF_ADDR_W      = 21;
    localparam int unsigned DEF_READ_CYCLES = 2;
    localparam int unsigned DEF_WE_CYCLES   = 2;

    localparam int unsigned REQ_ID_W = 2;
    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t REQ_VID = 2'd0;
    localparam req_id_t REQ_CPU = 2'd1;
    localparam req_id_t REQ_DMA = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_e;

endpackage

// File: rtl/sram_arb_select.sv
// Combinational winner select for the SRAM arbiter.
//   vid_req/cpu_req/dma_req : raw requests
//   vid_ack/cpu_ack/dma_ack : registered acks; a requester is ignored in its ack cycle
//   rr_dma                  : round-robin pointer, 1 = DMA preferred on CPU/DMA contention
//   grant_valid/grant_id    : winner, video has absolute priority
module sram_arb_select
    import sram_arb_pkg::*;
(
    input  logic       vid_req,
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic       vid_ack,
    input  logic       cpu_ack,
    input  logic       dma_ack,
    input  logic       rr_dma,
    output logic       grant_valid,
    output logic [1:0] grant_id
);

    logic vid_live;
    logic cpu_live;
    logic dma_live;

    assign vid_live = vid_req & ~vid_ack;
    assign cpu_live = cpu_req & ~cpu_ack;
    assign dma_live = dma_req & ~dma_ack;

    // Fixed priority for video, round-robin between CPU and DMA.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = REQ_VID;
        if (vid_live) begin
            grant_valid = 1'b1;
            grant_id    = REQ_VID;
        end else if (cpu_live && dma_live) begin
            grant_valid = 1'b1;
            grant_id    = rr_dma ? REQ_DMA : REQ_CPU;
        end else if (cpu_live) begin
            grant_valid = 1'b1;
            grant_id    = REQ_CPU;
        end else if (dma_live) begin
            grant_valid = 1'b1;
            grant_id    = REQ_DMA;
        end
    end

endmodule

// File: rtl/sram_arbiter_2mb.sv
// Shares one 2 MB 8-bit asynchronous SRAM between video (read-only), CPU and DMA,
// and owns all SRAM timing (address setup, WE pulse width, hold, read sampling).
//   clk_chipset, reset            : clock, synchronous active-high reset
//   vid_req/vid_addr/vid_ack      : video read port
//   cpu_* / dma_*                 : CPU and DMA ports (req, we, addr, wdata, ack)
//   rdata                         : shared read-data register, updated on read completion
//   sram_addr/sram_data_out/_oe   : SRAM address and write-data drive
//   sram_data_in                  : SRAM data input path
//   sram_we_n                     : SRAM write enable, active low
module sram_arbiter_2mb
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned READ_CYCLES = DEF_READ_CYCLES,
    parameter int unsigned WE_CYCLES   = DEF_WE_CYCLES
) (
    input  logic              clk_chipset,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_data_out,
    output logic              sram_data_oe,
    input  logic [7:0]        sram_data_in,
    output logic              sram_we_n
);

    localparam int unsigned MAX_CYC = (READ_CYCLES > WE_CYCLES) ? READ_CYCLES : WE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          owner_q, owner_d;
    logic                rr_dma_q, rr_dma_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          dout_q, dout_d;
    logic                oe_q, oe_d;
    logic                we_n_q, we_n_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                vid_ack_q, vid_ack_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                dma_ack_q, dma_ack_d;

    logic                grant_valid;
    logic [1:0]          grant_id;
    logic                contend;

    sram_arb_select u_select (
        .vid_req     (vid_req),
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .vid_ack     (vid_ack_q),
        .cpu_ack     (cpu_ack_q),
        .dma_ack     (dma_ack_q),
        .rr_dma      (rr_dma_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Pointer only moves when CPU and DMA actually competed for the slot.
    assign contend = ~(vid_req & ~vid_ack_q)
                   & (cpu_req & ~cpu_ack_q)
                   & (dma_req & ~dma_ack_q);

    // State register and all registered outputs.
    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            owner_q   <= REQ_VID;
            rr_dma_q  <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            oe_q      <= 1'b0;
            we_n_q    <= 1'b1;
            rdata_q   <= '0;
            vid_ack_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            rr_dma_q  <= rr_dma_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            we_n_q    <= we_n_d;
            rdata_q   <= rdata_d;
            vid_ack_q <= vid_ack_d;
            cpu_ack_q <= cpu_ack_d;
            dma_ack_q <= dma_ack_d;
        end
    end

    // Next-state and output sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        rr_dma_d  = rr_dma_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        we_n_d    = we_n_q;
        rdata_d   = rdata_q;
        vid_ack_d = 1'b0;
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_id;
                    cnt_d   = '0;
                    state_d = RD;
                    if (contend) begin
                        rr_dma_d = (grant_id == REQ_CPU);
                    end
                    case (grant_id)
                        REQ_CPU: begin
                            addr_d = cpu_addr;
                            if (cpu_we) begin
                                dout_d  = cpu_wdata;
                                oe_d    = 1'b1;
                                state_d = WR_SETUP;
                            end
                        end
                        REQ_DMA: begin
                            addr_d = dma_addr;
                            if (dma_we) begin
                                dout_d  = dma_wdata;
                                oe_d    = 1'b1;
                                state_d = WR_SETUP;
                            end
                        end
                        default: addr_d = vid_addr;
                    endcase
                end
            end

            RD: begin
                if (cnt_q == CNT_W'(READ_CYCLES - 1)) begin
                    rdata_d = sram_data_in;
                    state_d = IDLE;
                    case (owner_q)
                        REQ_CPU: cpu_ack_d = 1'b1;
                        REQ_DMA: dma_ack_d = 1'b1;
                        default: vid_ack_d = 1'b1;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = '0;
                state_d = WR_PULSE;
            end

            WR_PULSE: begin
                if (cnt_q == CNT_W'(WE_CYCLES - 1)) begin
                    we_n_d  = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WR_HOLD: begin
                oe_d    = 1'b0;
                state_d = IDLE;
                case (owner_q)
                    REQ_DMA: dma_ack_d = 1'b1;
                    default: cpu_ack_d = 1'b1;
                endcase
            end

            default: begin
                state_d = IDLE;
                we_n_d  = 1'b1;
                oe_d    = 1'b0;
            end
        endcase
    end

    assign vid_ack       = vid_ack_q;
    assign cpu_ack       = cpu_ack_q;
    assign dma_ack       = dma_ack_q;
    assign rdata         = rdata_q;
    assign sram_addr     = addr_q;
    assign sram_data_out = dout_q;
    assign sram_data_oe  = oe_q;
    assign sram_we_n     = we_n_q;

endmodule
